// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the regfile_sb register file.
//   clog2()    - constant-evaluable ceiling log2, used to size index ports
//   DEF_*      - default WIDTH / DEPTH / NRD / CNTW values
//   reg_idx_t  - register index type for the default DEPTH
package regfile_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NRD   = 2;
  localparam int DEF_CNTW  = 2;
  localparam int DEF_AW    = clog2(DEF_DEPTH);

  typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// regfile_sb_cnt: one saturating up/down pending-reservation counter.
//   clk    - clock, state changes on the falling edge
//   reset  - synchronous, active-low clear
//   inc    - reserve this register
//   dec    - writeback to this register
//   cnt    - current pending count
//   err    - combinational: this cycle's request over/underflows the count
// inc and dec together cancel: count holds and no error is flagged.
import regfile_pkg::*;

module regfile_sb_cnt #(
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            err
);

  localparam logic [CNTW-1:0] ONE = 1;

  logic up;
  logic down;
  logic at_max;
  logic at_zero;

  assign up      = inc & ~dec;
  assign down    = dec & ~inc;
  assign at_max  = &cnt;
  assign at_zero = (cnt == '0);
  assign err     = (up & at_max) | (down & at_zero);

  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(negedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (up && !at_max) begin
      cnt <= cnt + ONE;
    end else if (down && !at_zero) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register write-pending
// scoreboard for the LC-3b datapath.
//   clk      - clock; all state updates on the falling edge
//   reset    - synchronous, active-low; clears data, counters and sb_err
//   wr_n     - write strobe (active-low); writes data and releases one
//              reservation of wr_addr
//   wr_addr  - write register index
//   wr_data  - write data
//   rsv_n    - reserve strobe (active-low); adds a reservation to rsv_addr
//   rsv_addr - register being reserved
//   rd_addr  - NRD packed read indices, port k in slice k
//   rd_data  - NRD packed read data, combinational from rd_addr
//   rd_busy  - per read port: addressed register has pending reservations
//   busy     - per register: pending count is nonzero
//   sb_err   - sticky: unreserved write or reservation overflow seen
// Build option: define REGFILE_BYPASS_EN to forward the in-flight write to
// matching read ports, with rd_busy showing the post-writeback count.
import regfile_pkg::*;

module regfile_sb #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_n,
  input  logic [clog2(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rsv_n,
  input  logic [clog2(DEPTH)-1:0]  rsv_addr,
  input  logic [NRD*clog2(DEPTH)-1:0] rd_addr,
  output logic [NRD*WIDTH-1:0]     rd_data,
  output logic [NRD-1:0]           rd_busy,
  output logic [DEPTH-1:0]         busy,
  output logic                     sb_err
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] stor [DEPTH];
  logic [CNTW-1:0]  cnt_q [DEPTH];
  logic [DEPTH-1:0] cnt_err;
`ifdef REGFILE_BYPASS_EN
  logic [DEPTH-1:0] cnt_gt1;
`endif

  // One scoreboard counter per register.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
    regfile_sb_cnt #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (!rsv_n && (rsv_addr == AW'(i))),
      .dec   (!wr_n && (wr_addr == AW'(i))),
      .cnt   (cnt_q[i]),
      .err   (cnt_err[i])
    );
    assign busy[i] = (cnt_q[i] != '0);
`ifdef REGFILE_BYPASS_EN
    // Count still nonzero after this cycle's writeback releases one.
    assign cnt_gt1[i] = (cnt_q[i] > CNTW'(1));
`endif
  end

  // NOTE: the storage array is cleared on reset because software relies on
  // registers reading zero; this keeps it out of plain RAM macros.
  always_ff @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stor[i] <= '0;
    end else if (!wr_n) begin
      stor[wr_addr] <= wr_data;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      sb_err <= 1'b0;
    end else if (|cnt_err) begin
      sb_err <= 1'b1;
    end
  end

  logic [AW-1:0] idx;

  // NOTE: every output of this block is given a default before the loop so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    idx     = '0;
    for (int k = 0; k < NRD; k++) begin
      idx = rd_addr[k*AW +: AW];
      rd_data[k*WIDTH +: WIDTH] = stor[idx];
      rd_busy[k] = busy[idx];
`ifdef REGFILE_BYPASS_EN
      if (!wr_n && (wr_addr == idx)) begin
        rd_data[k*WIDTH +: WIDTH] = wr_data;
        rd_busy[k] = cnt_gt1[idx];
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb (default parameters).
// A behavioural model (plain arrays of register values and pending counts)
// is advanced at every falling edge; a compare process checks all outputs
// each cycle against it, and directed sequences pin literal values.
module tb_regfile_sb;

  localparam int W    = 16;
  localparam int D    = 8;
  localparam int N    = 2;
  localparam int C    = 2;
  localparam int AW   = 3;
  localparam int CMAX = (1 << C) - 1;

  logic            clk;
  logic            reset;
  logic            wr_n;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            rsv_n;
  logic [AW-1:0]   rsv_addr;
  logic [N*AW-1:0] rd_addr;
  logic [N*W-1:0]  rd_data;
  logic [N-1:0]    rd_busy;
  logic [D-1:0]    busy;
  logic            sb_err;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .NRD(N), .CNTW(C)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_n     (wr_n),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_n    (rsv_n),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy     (busy),
    .sb_err   (sb_err)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: register contents, pending counts, sticky error.
  int m_reg [D];
  int m_cnt [D];
  bit m_err;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < D; i++) begin
        m_reg[i] <= 0;
        m_cnt[i] <= 0;
      end
      m_err   <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (!wr_n && !rsv_n && wr_addr == rsv_addr) begin
        m_reg[wr_addr] <= int'(wr_data);
      end else begin
        if (!wr_n) begin
          m_reg[wr_addr] <= int'(wr_data);
          if (m_cnt[wr_addr] > 0) m_cnt[wr_addr] <= m_cnt[wr_addr] - 1;
          else m_err <= 1'b1;
        end
        if (!rsv_n) begin
          if (m_cnt[rsv_addr] < CMAX) m_cnt[rsv_addr] <= m_cnt[rsv_addr] + 1;
          else m_err <= 1'b1;
        end
      end
    end
  end

  // Compare process: inputs change at the rising edge, outputs are checked
  // 2 time units later, well before the falling (active) edge.
  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      logic [D-1:0] eb;
      for (int i = 0; i < D; i++) eb[i] = (m_cnt[i] != 0);
      for (int k = 0; k < N; k++) begin
        int a;
        int ed;
        bit ebz;
        a   = int'(rd_addr[k*AW +: AW]);
        ed  = m_reg[a];
        ebz = (m_cnt[a] != 0);
`ifdef REGFILE_BYPASS_EN
        if (!wr_n && int'(wr_addr) == a) begin
          ed  = int'(wr_data);
          ebz = (m_cnt[a] > 1);
        end
`endif
        check($sformatf("rd_data[%0d]", k), 32'(rd_data[k*W +: W]), 32'(ed));
        check($sformatf("rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(ebz));
      end
      check("busy", 32'(busy), 32'(eb));
      check("sb_err", 32'(sb_err), 32'(m_err));
    end
  end

  // Drive one cycle of inputs at the rising edge; they are sampled at the
  // following falling edge.
  task automatic step(input logic r, input logic wn, input int wa, input int wd,
                      input logic rn, input int ra, input int r0, input int r1);
    @(posedge clk);
    reset    = r;
    wr_n     = wn;
    wr_addr  = AW'(wa);
    wr_data  = W'(wd);
    rsv_n    = rn;
    rsv_addr = AW'(ra);
    rd_addr  = {AW'(r1), AW'(r0)};
  endtask

  task automatic idle(input int r0, input int r1);
    step(1'b1, 1'b1, 0, 0, 1'b1, 0, r0, r1);
  endtask

  task automatic rsv(input int ra);
    step(1'b1, 1'b1, 0, 0, 1'b0, ra, 0, 0);
  endtask

  task automatic wr(input int wa, input int wd);
    step(1'b1, 1'b0, wa, wd, 1'b1, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; wr_n = 1'b1; wr_addr = '0; wr_data = '0;
    rsv_n = 1'b1; rsv_addr = '0; rd_addr = '0;

    // Reset clears a previously written register.
    wr(3, 'h1234);
    step(1'b0, 1'b1, 0, 0, 1'b1, 0, 3, 5);
    idle(3, 5);
    #3;
    check("rst rd0", 32'(rd_data[15:0]), 32'h0);
    check("rst rd1", 32'(rd_data[31:16]), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst sb_err", 32'(sb_err), 32'h0);

    // Reset overrides a concurrent write.
    step(1'b0, 1'b0, 5, 'hAAAA, 1'b1, 0, 5, 5);
    idle(5, 3);
    #3;
    check("rst over wr", 32'(rd_data[15:0]), 32'h0);

    // Reserve then writeback.
    rsv(2);
    idle(2, 0);
    #3;
    check("rsv busy2", 32'(busy[2]), 32'h1);
    check("rsv rd_busy0", 32'(rd_busy[0]), 32'h1);
    wr(2, 'hBEEF);
    idle(2, 2);
    #3;
    check("wb busy2", 32'(busy[2]), 32'h0);
    check("wb rd0", 32'(rd_data[15:0]), 32'hBEEF);
    check("wb sb_err", 32'(sb_err), 32'h0);

    // Simultaneous reserve and write, same register.
    rsv(4);
    step(1'b1, 1'b0, 4, 'h4444, 1'b0, 4, 4, 4);
    idle(4, 0);
    #3;
    check("same busy4", 32'(busy[4]), 32'h1);
    check("same rd0", 32'(rd_data[15:0]), 32'h4444);

    // Simultaneous reserve and write, different registers.
    rsv(6);
    step(1'b1, 1'b0, 6, 'h6666, 1'b0, 0, 6, 0);
    idle(6, 0);
    #3;
    check("diff busy0", 32'(busy[0]), 32'h1);
    check("diff busy6", 32'(busy[6]), 32'h0);
    check("diff sb_err", 32'(sb_err), 32'h0);
    wr(4, 'h4445);
    wr(0, 'h0001);

    // Write forwarding (or not) to a read port before the edge.
    rsv(3);
    rsv(3);
    wr(3, 'h1111);
    step(1'b1, 1'b0, 3, 'h2222, 1'b1, 0, 0, 3);
    #3;
`ifdef REGFILE_BYPASS_EN
    check("byp pre rd1", 32'(rd_data[31:16]), 32'h2222);
    check("byp pre busy1", 32'(rd_busy[1]), 32'h0);
`else
    check("byp pre rd1", 32'(rd_data[31:16]), 32'h1111);
    check("byp pre busy1", 32'(rd_busy[1]), 32'h1);
`endif
    idle(0, 3);
    #3;
    check("byp post rd1", 32'(rd_data[31:16]), 32'h2222);
    check("byp post busy3", 32'(busy[3]), 32'h0);
    check("byp sb_err", 32'(sb_err), 32'h0);

    // Unreserved write still lands but flags an error.
    wr(7, 'h00FF);
    idle(7, 7);
    #3;
    check("unrsv rd0", 32'(rd_data[15:0]), 32'h00FF);
    check("unrsv sb_err", 32'(sb_err), 32'h1);

    // Counter saturation.
    step(1'b0, 1'b1, 0, 0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) rsv(1);
    idle(1, 1);
    #3;
    check("sat busy1", 32'(busy[1]), 32'h1);
    check("sat sb_err", 32'(sb_err), 32'h1);
    for (int i = 0; i < 3; i++) wr(1, 'h0100 + i);
    idle(1, 1);
    #3;
    check("sat drain busy1", 32'(busy[1]), 32'h0);
    check("sat drain rd0", 32'(rd_data[15:0]), 32'h0102);
    check("sat sticky", 32'(sb_err), 32'h1);

    // Randomized traffic with occasional resets.
    step(1'b0, 1'b1, 0, 0, 1'b1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) == 0) ? 1'b0 : 1'b1,
           1'($urandom_range(1)), int'($urandom_range(D-1)), int'($urandom_range(16'hFFFF)),
           1'($urandom_range(1)), int'($urandom_range(D-1)),
           int'($urandom_range(D-1)), int'($urandom_range(D-1)));
    end
    idle(0, 0);
    @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
